// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared definitions for the iterative InvMixColumns engine: widths, FSM state
// encodings and the GF(2^8) constant-multiplier cells (poly 0x11B).
package inv_mix_columns_seq_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Each constant is decomposed into doublings: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
  function automatic logic [7:0] gmul_9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul_b(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul_d(input logic [7:0] b);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul_e(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_col_row_mul.sv
// One inverse-MixColumns output row: the byte to be produced sits in [7:0] and its
// column neighbours follow in the upper bytes, so the coefficient order is fixed.
import inv_mix_columns_seq_pkg::*;

module inv_col_row_mul (
  input  logic [31:0] col_word,
  output logic [7:0]  row_byte
);

  assign row_byte = gmul_e(col_word[7:0])   ^
                    gmul_b(col_word[15:8])  ^
                    gmul_d(col_word[23:16]) ^
                    gmul_9(col_word[31:24]);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: a single shared row multiplier produces one output byte
// per cycle (16 cycles per state) behind valid/ready handshakes on both sides.
import inv_mix_columns_seq_pkg::*;

module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  state_t                 state;
  logic [3:0]             step;
  logic [AES_STATE_W-1:0] src_reg;
  logic [AES_STATE_W-1:0] res_reg;
  logic [AES_COL_W-1:0]   col_word;
  logic [AES_COL_W-1:0]   rot_word;
  logic [7:0]             mul_byte;
  logic [6:0]             col_base;
  logic [6:0]             byte_base;

  // step walks bytes in storage order: column in [3:2], row in [1:0].
  assign col_base  = {step[3:2], 5'd0};
  assign byte_base = {step, 3'd0};
  assign col_word  = src_reg[col_base +: AES_COL_W];

  always_comb begin
    rot_word = col_word;
    case (step[1:0])
      2'd1:    rot_word = {col_word[7:0],  col_word[31:8]};
      2'd2:    rot_word = {col_word[15:0], col_word[31:16]};
      2'd3:    rot_word = {col_word[23:0], col_word[31:24]};
      default: rot_word = col_word;
    endcase
  end

  inv_col_row_mul u_row_mul (
    .col_word (rot_word),
    .row_byte (mul_byte)
  );

  // The input copy carries no reset; it is only read while in RUN.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      src_reg <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      step    <= 4'd0;
      res_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            step  <= 4'd0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_reg[byte_base +: 8] <= mul_byte;
          step                    <= step + 4'd1;
          if (step == 4'd15) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          step  <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign data_out  = res_reg;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: known AES column vectors, handshake
// timing, backpressure, mid-run reset and back-to-back streaming.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] COL_VEC_IN  = {32'h01010101, 32'h01010101, 32'h01010101, 32'hbca14d8e};
  localparam logic [127:0] COL_VEC_OUT = {32'h01010101, 32'h01010101, 32'h01010101, 32'h455313db};
  localparam logic [127:0] FULL_IN     = {32'hbca14d8e, 32'hc6c6c6c6, 32'hd6d7d5d5, 32'h9d58dc9f};
  localparam logic [127:0] FULL_OUT    = {32'h455313db, 32'hc6c6c6c6, 32'hd5d4d4d4, 32'h5c220af2};

  always #5 clk = ~clk;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  // Shift-and-add GF(2^8) multiply, independent of the constant cells in the design.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[32*c + 8*k +: 8];
      for (int k = 0; k < 4; k++) begin
        r[32*c + 8*k +: 8] = gf_mul(a[k], 8'h0e) ^ gf_mul(a[(k+1)%4], 8'h0b) ^
                             gf_mul(a[(k+2)%4], 8'h0d) ^ gf_mul(a[(k+3)%4], 8'h09);
      end
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_state(input logic [127:0] d);
    in_valid = 1'b1;
    data_in  = d;
    tick();
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    if (!out_valid) cycles = -1;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = FULL_IN;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 128'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_column;
    int cyc;
    send_state(COL_VEC_IN);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL single_run_flags busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
    wait_out(cyc);
    checks++; if (cyc != 16) begin failures++; $display("FAIL single_latency got=%0d exp=16", cyc); end
    checks++; if (data_out !== COL_VEC_OUT) begin failures++; $display("FAIL single_data got=%h exp=%h", data_out, COL_VEC_OUT); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL single_drain out_valid=%b in_ready=%b exp out_valid=0 in_ready=1", out_valid, in_ready); end
  endtask

  task automatic test_full_state;
    int cyc;
    send_state(FULL_IN);
    wait_out(cyc);
    checks++; if (cyc != 16) begin failures++; $display("FAIL full_latency got=%0d exp=16", cyc); end
    checks++; if (data_out !== FULL_OUT) begin failures++; $display("FAIL full_data got=%h exp=%h", data_out, FULL_OUT); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int cyc;
    send_state(FULL_IN);
    wait_out(cyc);
    checks++; if (cyc != 16) begin failures++; $display("FAIL bp_latency got=%0d exp=16", cyc); end
    in_valid = 1'b1;
    data_in  = COL_VEC_IN;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cycle=%0d got=%b exp=1", i, out_valid); end
      checks++; if (data_out !== FULL_OUT) begin failures++; $display("FAIL bp_hold_data cycle=%0d got=%h exp=%h", i, data_out, FULL_OUT); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy); end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    logic saw_valid;
    send_state(FULL_IN);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_flags in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
    checks++; if (data_out !== 128'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", data_out); end
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_pulse got=%b exp=0", saw_valid); end
    send_state(COL_VEC_IN);
    wait_out(cyc);
    checks++; if (cyc != 16) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=16", cyc); end
    checks++; if (data_out !== COL_VEC_OUT) begin failures++; $display("FAIL midrst_next_data got=%h exp=%h", data_out, COL_VEC_OUT); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [127:0] states [3];
    int acc_cyc [3];
    int n_acc;
    int n_out;
    int cyc;
    logic [127:0] exp_val;
    states[0] = FULL_IN;
    states[1] = 128'h00112233_44556677_8899aabb_ccddeeff;
    states[2] = 128'hdeadbeef_01234567_89abcdef_f0e1d2c3;
    n_acc = 0;
    n_out = 0;
    cyc   = 0;
    out_ready = 1'b1;
    while ((n_acc < 3 || n_out < 3) && cyc < 120) begin
      if (out_valid && n_out < 3) begin
        exp_val = inv_mix(states[n_out]);
        checks++; if (data_out !== exp_val) begin failures++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", n_out, data_out, exp_val); end
        n_out++;
      end
      if (in_ready && n_acc < 3) begin
        data_in      = states[n_acc];
        in_valid     = 1'b1;
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end else begin
        in_valid = (n_acc < 3);
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (n_out != 3 || n_acc != 3) begin failures++; $display("FAIL b2b_count outputs=%0d accepts=%0d exp 3/3", n_out, n_acc); end
    if (n_acc == 3) begin
      checks++; if (acc_cyc[1] - acc_cyc[0] != 18) begin failures++; $display("FAIL b2b_spacing01 got=%0d exp=18", acc_cyc[1] - acc_cyc[0]); end
      checks++; if (acc_cyc[2] - acc_cyc[1] != 18) begin failures++; $display("FAIL b2b_spacing12 got=%0d exp=18", acc_cyc[2] - acc_cyc[1]); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    test_reset();
    test_single_column();
    test_full_state();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
